// File: rtl/tape_pulse_decoder.sv
// ============================================================================
// tape_pulse_decoder
// ----------------------------------------------------------------------------
// Front end of the tape loader. Times every half-pulse of the raw EAR level
// in 1 us units and recognises the ZX Spectrum pilot tone, the two sync
// half-pulses and the bit pulse pairs. The resulting start / bit / valid
// stream feeds the byte-capture stage.
//
// Ports:
//   clk            system clock (CLK_DIV cycles per microsecond)
//   reset_n        asynchronous active-low reset
//   ear_in         raw tape level, asynchronous to clk
//   sync_detected  1-cycle pulse once pilot + sync1 + sync2 are seen
//   data_bit       decoded bit, valid with data_valid, held until the next one
//   data_valid     1-cycle pulse per decoded bit
//   block_end      1-cycle pulse when the gap timeout hits while in DATA
//   state_out      debug state: IDLE=0, PILOT=1, SYNC=2, DATA=3
//   ear_level      synchronised EAR level for a debug LED
//   err_count      number of invalid-pulse aborts
//
// Optional feature:
//   TAPE_DECODER_STATS_EN  when defined, err_count is a saturating 16-bit
//                          counter of invalid-pulse aborts; otherwise it is
//                          tied to zero and no counter is built.
// ============================================================================
module tape_pulse_decoder #(
    parameter int CLK_DIV   = 27,
    parameter int PILOT_MIN = 256,
    parameter int GAP_US    = 2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ear_in,
    output logic        sync_detected,
    output logic        data_bit,
    output logic        data_valid,
    output logic        block_end,
    output logic [1:0]  state_out,
    output logic        ear_level,
    output logic [15:0] err_count
);

    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0]      GAP_LIMIT  = 12'(GAP_US);
    localparam logic [9:0]       PILOT_NEED = 10'(PILOT_MIN);

    // Class boundaries in microseconds, each one inclusive-low.
    localparam logic [11:0] W_SHORT_MIN = 12'd150;
    localparam logic [11:0] W_LONG_MIN  = 12'd350;
    localparam logic [11:0] W_PILOT_MIN = 12'd550;
    localparam logic [11:0] W_BAD_MIN   = 12'd800;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PILOT = 2'd1,
        ST_SYNC  = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOISE,
        CLS_SHORT,
        CLS_LONG,
        CLS_PILOT,
        CLS_BAD
    } pulse_class_t;

    logic             s1, s2, s3;
    logic             ear_edge;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [11:0]      width_cnt;
    pulse_class_t     width_class;
    logic             timeout;

    state_t           state, state_next;
    logic [9:0]       pilot_cnt, pilot_cnt_next;
    logic             half_flag, half_flag_next;
    logic             pending_long, pending_long_next;
    logic             sync_next, valid_next, bit_next, block_end_next;

    // ------------------------------------------------------------------
    // Two-stage synchroniser plus a history stage; any difference between
    // the last two synchronised samples marks the end of a half-pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ear_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ear_edge  = s2 ^ s3;
    assign ear_level = s2;

    // ------------------------------------------------------------------
    // Microsecond prescaler. It restarts on every edge so that each
    // half-pulse is measured from a clean phase.
    // ------------------------------------------------------------------
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (ear_edge || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Half-pulse width in microseconds. The value present when an edge
    // arrives is the width of the half that just ended; saturating at 4095
    // keeps a long silence from wrapping back into a valid class.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            width_cnt <= 12'd0;
        end else if (ear_edge) begin
            width_cnt <= 12'd0;
        end else if (tick && (width_cnt != 12'hFFF)) begin
            width_cnt <= width_cnt + 12'd1;
        end
    end

    // Sort the measured width into one of the five pulse classes.
    always_comb begin
        width_class = CLS_BAD;
        if (width_cnt < W_SHORT_MIN) begin
            width_class = CLS_NOISE;
        end else if (width_cnt < W_LONG_MIN) begin
            width_class = CLS_SHORT;
        end else if (width_cnt < W_PILOT_MIN) begin
            width_class = CLS_LONG;
        end else if (width_cnt < W_BAD_MIN) begin
            width_class = CLS_PILOT;
        end
    end

    // A gap only matters once a block has started; IDLE ignores silence.
    assign timeout = (width_cnt >= GAP_LIMIT) && (state != ST_IDLE);

    // ------------------------------------------------------------------
    // State register and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            pilot_cnt     <= 10'd0;
            half_flag     <= 1'b0;
            pending_long  <= 1'b0;
            sync_detected <= 1'b0;
            data_valid    <= 1'b0;
            data_bit      <= 1'b0;
            block_end     <= 1'b0;
        end else begin
            state         <= state_next;
            pilot_cnt     <= pilot_cnt_next;
            half_flag     <= half_flag_next;
            pending_long  <= pending_long_next;
            sync_detected <= sync_next;
            data_valid    <= valid_next;
            data_bit      <= bit_next;
            block_end     <= block_end_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. An edge always takes priority over a timeout that
    // happens in the same cycle, so a half ending exactly at the gap limit
    // is still classified. Every return to IDLE clears the pilot count and
    // the half flag so the next block starts from scratch.
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state;
        pilot_cnt_next    = pilot_cnt;
        half_flag_next    = half_flag;
        pending_long_next = pending_long;
        sync_next         = 1'b0;
        valid_next        = 1'b0;
        bit_next          = data_bit;
        block_end_next    = 1'b0;

        if (ear_edge) begin
            case (state)
                ST_IDLE: begin
                    if (width_class == CLS_PILOT) begin
                        state_next     = ST_PILOT;
                        pilot_cnt_next = 10'd1;
                    end
                end

                ST_PILOT: begin
                    case (width_class)
                        CLS_PILOT: begin
                            if (pilot_cnt != 10'h3FF) begin
                                pilot_cnt_next = pilot_cnt + 10'd1;
                            end
                        end
                        CLS_SHORT: begin
                            if (pilot_cnt >= PILOT_NEED) begin
                                state_next = ST_SYNC;
                            end else begin
                                state_next     = ST_IDLE;
                                pilot_cnt_next = 10'd0;
                            end
                        end
                        default: begin
                            state_next     = ST_IDLE;
                            pilot_cnt_next = 10'd0;
                        end
                    endcase
                end

                ST_SYNC: begin
                    if (width_class == CLS_SHORT) begin
                        state_next     = ST_DATA;
                        sync_next      = 1'b1;
                        half_flag_next = 1'b0;
                    end else begin
                        state_next     = ST_IDLE;
                        pilot_cnt_next = 10'd0;
                        half_flag_next = 1'b0;
                    end
                end

                ST_DATA: begin
                    // A bit is two equal halves: remember the class of the
                    // first, then demand the same class for the second.
                    if ((width_class == CLS_SHORT) || (width_class == CLS_LONG)) begin
                        if (!half_flag) begin
                            pending_long_next = (width_class == CLS_LONG);
                            half_flag_next    = 1'b1;
                        end else if ((width_class == CLS_LONG) == pending_long) begin
                            valid_next     = 1'b1;
                            bit_next       = pending_long;
                            half_flag_next = 1'b0;
                        end else begin
                            state_next     = ST_IDLE;
                            pilot_cnt_next = 10'd0;
                            half_flag_next = 1'b0;
                        end
                    end else begin
                        state_next     = ST_IDLE;
                        pilot_cnt_next = 10'd0;
                        half_flag_next = 1'b0;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end else if (timeout) begin
            state_next     = ST_IDLE;
            pilot_cnt_next = 10'd0;
            half_flag_next = 1'b0;
            block_end_next = (state == ST_DATA);
        end
    end

    assign state_out = state;

`ifdef TAPE_DECODER_STATS_EN
    logic        err_event;
    logic [15:0] err_cnt_q;

    // On an edge, leaving a busy state for IDLE is always an invalid-class
    // abort, except for the pilot-too-short case which is a normal outcome.
    assign err_event = ear_edge && (state != ST_IDLE) && (state_next == ST_IDLE) &&
                       !((state == ST_PILOT) && (width_class == CLS_SHORT));

    // Abort statistics; saturates instead of wrapping and clears only on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= 16'd0;
        end else if (err_event && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'd0;
`endif

endmodule

// File: doc/tape_pulse_decoder.md
# tape_pulse_decoder

Front-end decoder of the tape loader. It takes the raw EAR level from the tape input and times each half-pulse in microseconds. It recognises the ZX Spectrum pilot tone, the two sync half-pulses and the bit pulse pairs. Its outputs are the `start`/`data_bit`/`data_valid` stream that the byte-capture stage turns into bytes in tape memory.

## Interface
Parameters:
- `CLK_DIV`, 27: clk cycles per 1 µs tick (27 MHz system clock).
- `PILOT_MIN`, 256: pilot half-pulses required before a sync is accepted.
- `GAP_US`, 2000: silence after which a block is considered ended.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `ear_in` in 1: raw tape level, asynchronous to clk.
- `sync_detected` out 1: 1-cycle pulse when pilot + sync1 + sync2 complete; drives capture `start`.
- `data_bit` out 1: decoded bit, valid with `data_valid`.
- `data_valid` out 1: 1-cycle pulse per decoded bit.
- `block_end` out 1: 1-cycle pulse on timeout while in DATA.
- `state_out` out 2: debug state; IDLE=0, PILOT=1, SYNC=2, DATA=3.
- `ear_level` out 1: synchronised EAR level, for a debug LED.
- `err_count` out 16: invalid-pulse aborts (see Configuration).

## Operation
- **Input path:** `ear_in` passes through a 2-FF synchroniser (s1, s2). A third register s3 holds the previous level. `edge = s2 ^ s3`.
- **Tick generator:** counts 0..CLK_DIV-1 and emits a 1 µs tick on wrap.
- **Width counter:**
  - 12-bit; increments on each tick and saturates at 4095.
  - On `edge`, its current value is taken as the half-pulse width, and the counter clears to 0. The tick prescaler also clears.
- **Width classes, W in µs, boundaries inclusive-low:**
  - NOISE: W < 150.
  - SHORT: 150 ≤ W < 350. Covers sync1 ≈190, sync2 ≈210 and bit0 ≈244.
  - LONG: 350 ≤ W < 550. Covers bit1 ≈489.
  - PILOT: 550 ≤ W < 800. Nominal 619.
  - BAD: W ≥ 800.
- **FSM, evaluated on each `edge`:**
  - **IDLE:**
    - PILOT → enter PILOT with pilot_cnt=1.
    - Anything else → stay in IDLE, with no error counted.
  - **PILOT:**
    - PILOT → pilot_cnt+1. pilot_cnt is 10-bit and saturates at 1023.
    - SHORT with pilot_cnt ≥ PILOT_MIN → enter SYNC.
    - SHORT with pilot_cnt < PILOT_MIN → return to IDLE.
    - Any other class → error, return to IDLE.
  - **SYNC:**
    - SHORT → enter DATA, pulse `sync_detected`, clear the half flag.
    - Anything else → error, return to IDLE.
  - **DATA:**
    - First half: SHORT or LONG is stored as the pending class, and the half flag is set.
    - Second half, same class as pending → emit `data_bit` (0 for SHORT, 1 for LONG), pulse `data_valid`, clear the half flag.
    - Second half, class mismatch → error, return to IDLE.
    - NOISE, PILOT or BAD in either half → error, return to IDLE.
- **Timeout:**
  - Applies when the width counter reaches GAP_US in any state other than IDLE.
  - The FSM goes to IDLE. The half flag and pilot_cnt clear.
  - If the state was DATA, `block_end` pulses, including mid-pair; the partial bit is dropped.
  - Timeout is not an error.
- **Bit order:** bits are emitted in tape order (MSB of each byte first). Packing is the downstream stage's job.
- **Error events:**
  - "Error" means an abort with an invalid class.
  - Only these increment the stats counter.
  - The PILOT→IDLE abort for too few pilot halves is not an error.

## Timing
- **Reset values:** all outputs are 0, the state is IDLE, and all counters are 0. s1, s2 and s3 reset to 0.
- **Output registers:** `sync_detected`, `data_valid`, `data_bit` and `block_end` are registered. Each pulses exactly 1 cycle.
- **Edge-to-output latency:** the output asserts on the 3rd rising clk after the first clk edge that samples the new `ear_in` level. The three stages are s1, then s2/edge, then the output register.
- **data_bit hold:** `data_bit` holds its value until the next `data_valid`.
- **Simultaneous edge and timeout:** the edge wins.
- **reset_n mid-operation:** everything returns to reset values immediately, asynchronously. No pulse is emitted on release.
- **Saturation:** a width counter saturated at 4095 classifies as BAD.

## Configuration
- `TAPE_DECODER_STATS_EN` defined:
  - `err_count` is a 16-bit counter of error events.
  - It saturates at 0xFFFF and clears only on reset.
- Undefined:
  - `err_count` is tied to 16'd0 and no counter logic is built.

## Test plan
- **Valid block:** 300 halves of 619 µs, then 190 µs, then 210 µs, then byte 0xA5 as pairs (bit0 = 244/244 µs, bit1 = 489/489 µs) → one `sync_detected` pulse; 8 `data_valid` pulses with bits 1,0,1,0,0,1,0,1; `state_out`=3.
- **Short pilot:** 100 pilot halves then 190 µs → no `sync_detected`; `state_out`=0; `err_count` unchanged.
- **Mismatched pair:** after a valid sync, halves 244 then 489 µs → no `data_valid`; IDLE; `err_count`+1 (macro defined), 0 (undefined).
- **End-of-block gap:** after 3 valid bits, hold `ear_in` for 2500 µs → exactly one `block_end`, asserted at width counter = 2000 µs; IDLE.
- **Glitch:** a 50 µs half in DATA → IDLE, `err_count`+1, no `data_valid`.
- **Reset mid-byte:** `reset_n` low mid-byte → all outputs 0, IDLE; the full valid-block sequence replayed afterwards decodes 0xA5 correctly.
